// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: shares one RAM port between the CPU and a burst loader.
// Define ARB_ROUND_ROBIN_EN for round-robin ownership; default is fixed CPU priority.
module data_mem_arbiter #(
    parameter int DW    = 32,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [DW-1:0]    cpu_addr_i,
    input  logic [DW-1:0]    cpu_wd_i,
    input  logic             cpu_addrsel_i,
    output logic             cpu_gnt_o,
    output logic             cpu_stall_o,
    output logic [DW-1:0]    cpu_rd_o,
    input  logic             ldr_req_i,
    input  logic             ldr_we_i,
    input  logic [DW-1:0]    ldr_addr_i,
    input  logic [DW-1:0]    ldr_wd_i,
    input  logic [LEN_W-1:0] ldr_len_i,
    output logic             ldr_gnt_o,
    output logic             ldr_done_o,
    output logic             ram_we_o,
    output logic [DW-1:0]    ram_addr_o,
    output logic [DW-1:0]    ram_wd_o,
    output logic             ram_addrsel_o,
    input  logic [DW-1:0]    ram_rd_i
);

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        LDR
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic             cpu_first;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ldr_q;
    // Tie in IDLE goes to whichever master was not served last.
    assign cpu_first = last_ldr_q;
`else
    assign cpu_first = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_ldr_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ldr_req_i && !(cpu_req_i && cpu_first)) begin
                        state_q <= LDR;
                        cnt_q   <= ldr_len_i;
                    end else if (cpu_req_i) begin
                        state_q <= CPU;
                    end
                end
                CPU: begin
                    if (!cpu_req_i) begin
                        state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    end else if (ldr_req_i) begin
                        state_q <= LDR;
                        cnt_q   <= ldr_len_i;
`endif
                    end
                end
                LDR: begin
                    // Burst only advances on granted beats; a paused loader keeps ownership.
                    if (ldr_req_i) begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            if (cpu_gnt_o) begin
                last_ldr_q <= 1'b0;
            end else if (ldr_gnt_o) begin
                last_ldr_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        cpu_gnt_o     = 1'b0;
        ldr_gnt_o     = 1'b0;
        ram_we_o      = 1'b0;
        ram_addr_o    = '0;
        ram_wd_o      = '0;
        ram_addrsel_o = 1'b0;
        unique case (state_q)
            CPU: begin
                cpu_gnt_o     = cpu_req_i;
                ram_we_o      = cpu_we_i & cpu_req_i;
                ram_addr_o    = cpu_addr_i;
                ram_wd_o      = cpu_wd_i;
                ram_addrsel_o = cpu_addrsel_i;
            end
            LDR: begin
                ldr_gnt_o  = ldr_req_i;
                ram_we_o   = ldr_we_i & ldr_req_i;
                ram_addr_o = ldr_addr_i;
                ram_wd_o   = ldr_wd_i;
            end
            default: ;
        endcase
    end

    assign ldr_done_o  = ldr_gnt_o & (cnt_q == '0);
    // Stall is masked while reset is held so every output reads zero.
    assign cpu_stall_o = rst & cpu_req_i & ~cpu_gnt_o;
    assign cpu_rd_o    = cpu_gnt_o ? ram_rd_i : '0;

endmodule
